// File: rtl/pipe_mult_fu_pkg.sv
// Shared ALU function encodings plus small helpers that classify the multiply variants.
package pipe_mult_fu_pkg;

  localparam int ALU_FUNC_W = 4;
  typedef logic [ALU_FUNC_W-1:0] alu_func_t;

  localparam alu_func_t ALU_ADD    = 4'd0;
  localparam alu_func_t ALU_SUB    = 4'd1;
  localparam alu_func_t ALU_MUL    = 4'd10;
  localparam alu_func_t ALU_MULH   = 4'd11;
  localparam alu_func_t ALU_MULHSU = 4'd12;
  localparam alu_func_t ALU_MULHU  = 4'd13;

  // Unknown encodings behave as ALU_MUL, so only the three high-half variants are special.
  function automatic logic func_high_half(input alu_func_t f);
    return (f == ALU_MULH) || (f == ALU_MULHSU) || (f == ALU_MULHU);
  endfunction

  function automatic logic func_opa_signed(input alu_func_t f);
    return (f != ALU_MULHU);
  endfunction

  function automatic logic func_opb_signed(input alu_func_t f);
    return (f != ALU_MULHSU) && (f != ALU_MULHU);
  endfunction

endpackage

// File: rtl/pipe_mult_fu_stage.sv
// One shift-and-add pipeline stage: folds 2*XLEN/STAGES multiplier bits into the partial sum.
module mult_pipe_stage
  import pipe_mult_fu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6
) (
  input  logic              clock,
  input  logic              enable,
  input  logic              clear,
  input  logic              in_valid,
  input  alu_func_t         in_func,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [2*XLEN-1:0] in_acc,
  input  logic [2*XLEN-1:0] in_mcand,
  input  logic [2*XLEN-1:0] in_mplier,
  output logic              out_valid,
  output alu_func_t         out_func,
  output logic [TAG_W-1:0]  out_tag,
  output logic [2*XLEN-1:0] out_acc,
  output logic [2*XLEN-1:0] out_mcand,
  output logic [2*XLEN-1:0] out_mplier
);

  localparam int PW = 2 * XLEN;
  localparam int K  = PW / STAGES;

  typedef struct packed {
    logic             valid;
    alu_func_t        func;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    mplier;
  } stage_t;

  stage_t stage_reg;
  stage_t stage_next;

  always_comb begin
    stage_next.valid  = in_valid;
    stage_next.func   = in_func;
    stage_next.tag    = in_tag;
    stage_next.acc    = in_acc;
    for (int j = 0; j < K; j++) begin
      if (in_mplier[j]) stage_next.acc = stage_next.acc + (in_mcand << j);
    end
    stage_next.mcand  = in_mcand << K;
    stage_next.mplier = in_mplier >> K;
  end

  // Clear only drops the valid bit; stale payload is harmless because outputs are gated by valid.
  always_ff @(posedge clock) begin
    if (clear) begin
      stage_reg.valid <= 1'b0;
    end else if (enable) begin
      stage_reg <= stage_next;
    end
  end

  assign out_valid  = stage_reg.valid;
  assign out_func   = stage_reg.func;
  assign out_tag    = stage_reg.tag;
  assign out_acc    = stage_reg.acc;
  assign out_mcand  = stage_reg.mcand;
  assign out_mplier = stage_reg.mplier;

endmodule

// File: rtl/pipe_mult_fu.sv
// Fully pipelined integer multiplier unit (MUL/MULH/MULHSU/MULHU) with valid/ready handshake and squash.
module pipe_mult_fu
  import pipe_mult_fu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             refresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  opa,
  input  logic [XLEN-1:0]  opb,
  input  alu_func_t        func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = 2 * XLEN;

  logic              stall;
  logic              enable;
  logic              clear;
  logic [STAGES:0]   valid_c;
  alu_func_t         func_c   [0:STAGES];
  logic [TAG_W-1:0]  tag_c    [0:STAGES];
  logic [PW-1:0]     acc_c    [0:STAGES];
  logic [PW-1:0]     mcand_c  [0:STAGES];
  logic [PW-1:0]     mplier_c [0:STAGES];
  logic              unused_tail;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign enable   = !stall;
  assign clear    = reset || refresh;

  // Stage 0 inputs: operands extended to 2*XLEN so the modulo product's upper half is exact.
  assign valid_c[0]  = in_valid;
  assign func_c[0]   = func;
  assign tag_c[0]    = in_tag;
  assign acc_c[0]    = '0;
  assign mcand_c[0]  = {{XLEN{func_opa_signed(func) & opa[XLEN-1]}}, opa};
  assign mplier_c[0] = {{XLEN{func_opb_signed(func) & opb[XLEN-1]}}, opb};

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      mult_pipe_stage #(
        .XLEN  (XLEN),
        .STAGES(STAGES),
        .TAG_W (TAG_W)
      ) u_stage (
        .clock     (clock),
        .enable    (enable),
        .clear     (clear),
        .in_valid  (valid_c[gi]),
        .in_func   (func_c[gi]),
        .in_tag    (tag_c[gi]),
        .in_acc    (acc_c[gi]),
        .in_mcand  (mcand_c[gi]),
        .in_mplier (mplier_c[gi]),
        .out_valid (valid_c[gi+1]),
        .out_func  (func_c[gi+1]),
        .out_tag   (tag_c[gi+1]),
        .out_acc   (acc_c[gi+1]),
        .out_mcand (mcand_c[gi+1]),
        .out_mplier(mplier_c[gi+1])
      );
    end
  endgenerate

  // The last stage's shifted operands are fully consumed and intentionally dropped.
  assign unused_tail = ^{mcand_c[STAGES], mplier_c[STAGES]};

  assign out_valid = valid_c[STAGES];
  assign out_tag   = out_valid ? tag_c[STAGES] : '0;
  assign result    = !out_valid ? '0 :
                     func_high_half(func_c[STAGES]) ? acc_c[STAGES][PW-1:XLEN]
                                                    : acc_c[STAGES][XLEN-1:0];

endmodule

// File: tb/tb_pipe_mult_fu.sv
// Scoreboard bench for pipe_mult_fu: directed corner cases then randomized traffic with stalls and squashes.
module tb_pipe_mult_fu;
  import pipe_mult_fu_pkg::*;

  localparam int XLEN   = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 6;

  logic             clock;
  logic             reset;
  logic             refresh;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  opa;
  logic [XLEN-1:0]  opb;
  alu_func_t        func;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;

  pipe_mult_fu #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .refresh(refresh),
    .in_valid(in_valid), .in_ready(in_ready), .opa(opa), .opb(opb),
    .func(func), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               acc_cycle;
    int               stall_base;
  } exp_t;

  exp_t             sb[$];
  int               cycle = 0;
  int               n_vec = 0;
  int               n_bad = 0;
  int               stall_total = 0;
  int               n_retired = 0;
  bit               front_seen = 0;
  bit               was_stall = 0;
  logic [XLEN+TAG_W-1:0] last_out;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands as the function interprets them.
  function automatic logic [XLEN-1:0] model(input alu_func_t f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sbv;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (f)
      ALU_MULH:   begin p = sa * sbv;          return p[63:32]; end
      ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub;           return p[63:32]; end
      default:    begin p = ua * ub;           return p[31:0];  end
    endcase
  endfunction

  // One cycle of stimulus; expected results are queued at issue time.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input alu_func_t f,
                      input logic [TAG_W-1:0] t, input bit ordy, input bit rf, input bit rst);
    exp_t e;
    @(posedge clock);
    #1;
    in_valid = v; opa = a; opb = b; func = f; in_tag = t;
    out_ready = ordy; refresh = rf; reset = rst;
    #1;
    if (rst || rf) begin
      sb.delete();
      front_seen = 0;
    end else if (v && in_ready) begin
      e.res = model(f, a, b); e.tag = t; e.acc_cycle = cycle; e.stall_base = stall_total;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, ALU_MUL, 0, ordy, 0, 0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares the presented result against the oldest outstanding op.
  always @(negedge clock) begin
    if (was_stall) chk("stall_hold", {result, out_tag}, last_out);
    was_stall = 0;
    if (!reset && !refresh) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spurious_out @cycle %0d: got result %0h tag %0h, required no output", cycle, result, out_tag);
        end else begin
          chk("result", result, sb[0].res);
          chk("out_tag", out_tag, sb[0].tag);
          if (!front_seen)
            chk("latency", cycle - sb[0].acc_cycle - (stall_total - sb[0].stall_base), STAGES);
          front_seen = 1;
          if (out_ready) begin
            void'(sb.pop_front());
            front_seen = 0;
            n_retired++;
          end else begin
            stall_total++;
            was_stall = 1;
            last_out = {result, out_tag};
          end
        end
      end else begin
        chk("idle_result", result, 0);
        chk("idle_tag", out_tag, 0);
      end
    end
  end

  initial begin
    logic [31:0] exp_hi [3];
    int          base;
    reset = 1; refresh = 0; in_valid = 0; opa = 0; opb = 0; func = ALU_MUL; in_tag = 0; out_ready = 1;
    step(0, 0, 0, ALU_MUL, 0, 1, 0, 1);
    step(0, 0, 0, ALU_MUL, 0, 1, 0, 1);
    idle(1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_in_ready", in_ready, 1);

    // Single MUL with a negative multiplier: 7 * -3.
    step(1, 32'd7, 32'hFFFF_FFFD, ALU_MUL, 5, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      chk("mul_latency_valid", out_valid, (i == 4));
    end
    chk("mul_result", result, 32'hFFFF_FFEB);
    chk("mul_tag", out_tag, 5);
    idle(1);

    // High-half variants back to back.
    exp_hi[0] = 32'h4000_0000; exp_hi[1] = 32'hFFFF_FFFE; exp_hi[2] = 32'hFFFF_FFFF;
    step(1, 32'h8000_0000, 32'h8000_0000, ALU_MULH, 1, 1, 0, 0);
    step(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MULHU, 2, 1, 0, 0);
    step(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MULHSU, 3, 1, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("mulh_variant", result, exp_hi[i]);
    end
    idle(1);

    // Squares on consecutive cycles.
    for (int i = 0; i < 4; i++) step(1, i + 1, i + 1, ALU_MUL, TAG_W'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("square_valid", out_valid, 1);
      chk("square_result", result, (i + 1) * (i + 1));
      chk("square_tag", out_tag, i);
    end
    idle(1);

    // Full pipe held by out_ready=0 for three cycles, then drained.
    base = n_retired;
    for (int i = 0; i < 4; i++) step(1, rnd_op(), rnd_op(), ALU_MULH, TAG_W'(10 + i), 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, rnd_op(), rnd_op(), ALU_MUL, 6'd63, 0, 0, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    for (int i = 0; i < 6; i++) idle(1);
    chk("stall_drain_count", n_retired - base, 4);
    chk("stall_drain_empty", sb.size(), 0);

    // Squash with three ops in flight and one presented alongside refresh.
    for (int i = 0; i < 3; i++) step(1, rnd_op(), rnd_op(), ALU_MUL, TAG_W'(20 + i), 1, 0, 0);
    step(1, 32'd9, 32'd9, ALU_MUL, 23, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("refresh_quiet", out_valid, 0);
    end
    step(1, 32'd6, 32'd7, ALU_MUL, 24, 1, 0, 0);
    for (int i = 0; i < 4; i++) idle(1);
    chk("refresh_followup_valid", out_valid, 1);
    chk("refresh_followup_result", result, 42);
    idle(1);

    // Reset arriving while stalled.
    for (int i = 0; i < 4; i++) step(1, rnd_op(), rnd_op(), ALU_MULHU, TAG_W'(30 + i), 1, 0, 0);
    step(0, 0, 0, ALU_MUL, 0, 0, 0, 0);
    step(0, 0, 0, ALU_MUL, 0, 0, 0, 0);
    step(1, 32'd3, 32'd3, ALU_MUL, 1, 0, 0, 1);
    step(0, 0, 0, ALU_MUL, 0, 0, 0, 0);
    chk("reset_stall_valid", out_valid, 0);
    chk("reset_stall_result", result, 0);
    chk("reset_stall_in_ready", in_ready, 1);
    idle(1);

    // Randomized traffic, including unassigned func encodings and occasional squashes.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), alu_func_t'($urandom_range(0, 15)),
           TAG_W'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, 0);
    end
    for (int i = 0; i < 12; i++) idle(1);
    chk("final_drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
